dcache_direct: RTL

//  Direct-mapped, write-through, no-write-allocate L1 data cache between CPU dcache_* port and memory bus.

---
 rtl/dcache_direct.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits answer in the request cycle; misses stall for a LINE_WORDS-beat refill.
// Every store is forwarded to memory and merged into the line only on a hit.
module dcache_direct #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_rreq_i,
  input  logic [31:0] dcache_raddr_i,
  input  logic        dcache_wreq_i,
  input  logic [31:0] dcache_waddr_i,
  input  logic [31:0] dcache_wdata_i,
  input  logic [3:0]  dcache_wsel_i,
  output logic [31:0] dcache_data_o,
  output logic        dcache_stall_o,
  output logic        mem_rreq_o,
  output logic [31:0] mem_raddr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_wreq_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wsel_o,
  input  logic        mem_wack_i
);

  localparam int unsigned OFF  = $clog2(LINE_WORDS);
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - OFF - 2 - IDX;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][LINE_WORDS];
  logic [OFF-1:0]  beat_q;

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [OFF-1:0]  rd_off, wr_off;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;
  logic            refill_beat, refill_last, write_done, start_refill;
  logic            unused_addr_lsb;

  assign rd_idx = dcache_raddr_i[IDX+OFF+1:OFF+2];
  assign rd_off = dcache_raddr_i[OFF+1:2];
  assign rd_tag = dcache_raddr_i[31:IDX+OFF+2];
  assign wr_idx = dcache_waddr_i[IDX+OFF+1:OFF+2];
  assign wr_off = dcache_waddr_i[OFF+1:2];
  assign wr_tag = dcache_waddr_i[31:IDX+OFF+2];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign refill_beat  = !rst && (state_q == REFILL) && mem_rvalid_i;
  assign refill_last  = refill_beat && (beat_q == LAST_BEAT);
  assign write_done   = !rst && (state_q == WRITE) && mem_wack_i;
  assign start_refill = !rst && (state_q == IDLE) && !dcache_wreq_i && dcache_rreq_i && !rd_hit;

  assign unused_addr_lsb = ^{dcache_raddr_i[1:0], dcache_waddr_i[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Valid bits and refill beat counter; the target line is invalidated while it refills
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      beat_q  <= '0;
    end else begin
      if (start_refill) begin
        valid_q[rd_idx] <= 1'b0;
        beat_q          <= '0;
      end
      if (refill_beat) beat_q <= beat_q + OFF'(1);
      if (refill_last) valid_q[rd_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill beats and write-hit byte merges
  always_ff @(posedge clk) begin
    if (refill_beat) data_q[rd_idx][beat_q] <= mem_rdata_i;
    if (refill_last) tag_q[rd_idx] <= rd_tag;
    if (write_done && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dcache_wsel_i[b]) data_q[wr_idx][wr_off][8*b +: 8] <= dcache_wdata_i[8*b +: 8];
      end
    end
  end

  // Next state and CPU/memory handshake outputs; reset forces everything idle immediately
  always_comb begin
    state_d        = state_q;
    dcache_data_o  = '0;
    dcache_stall_o = 1'b0;
    mem_rreq_o     = 1'b0;
    mem_raddr_o    = '0;
    mem_wreq_o     = 1'b0;
    mem_waddr_o    = '0;
    mem_wdata_o    = '0;
    mem_wsel_o     = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (dcache_wreq_i) begin
            dcache_stall_o = 1'b1;
            state_d        = WRITE;
          end else if (dcache_rreq_i) begin
            if (rd_hit) begin
              dcache_data_o = data_q[rd_idx][rd_off];
            end else begin
              dcache_stall_o = 1'b1;
              state_d        = REFILL;
            end
          end
        end
        REFILL: begin
          dcache_stall_o = 1'b1;
          mem_rreq_o     = 1'b1;
          mem_raddr_o    = {dcache_raddr_i[31:OFF+2], (OFF+2)'(0)};
          if (refill_last) state_d = IDLE;
        end
        WRITE: begin
          mem_wreq_o     = 1'b1;
          mem_waddr_o    = dcache_waddr_i;
          mem_wdata_o    = dcache_wdata_i;
          mem_wsel_o     = dcache_wsel_i;
          dcache_stall_o = !mem_wack_i;
          if (mem_wack_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
